dmac_xfer_engine: RTL and testbench
===================================

DMAC_XFER_ENGINE -- requirements
Module: dmac_xfer_engine

Interface
REQ-001 Parameter ADDR_W, default 16, width of the source address, destination address and cfg_data.
REQ-002 Parameter CNT_W, default 8, width of the transfer-count register; CNT_W SHALL be <= ADDR_W.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_sel  input  2  register select: 0 = SRC, 1 = DST, 2 = CNT, 3 = reserved (write ignored).
REQ-007 cfg_data  input  ADDR_W  write data; CNT takes the low CNT_W bits.
REQ-008 start  input  1  single-cycle pulse that starts a block transfer.
REQ-009 abort  input  1  terminates the transfer in progress.
REQ-010 bus_req  output  1  memory access request.
REQ-011 bus_we  output  1  access direction: 0 = read, 1 = write.
REQ-012 bus_addr  output  ADDR_W  access address.
REQ-013 bus_wdata  output  8  write data.
REQ-014 bus_rdata  input  8  read data; valid when bus_ack is high during a read.
REQ-015 bus_ack  input  1  access complete; sampled only while bus_req = 1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse; this is the transfer-acknowledge input of the upstream DMA control FSM.
REQ-018 tc  output  1  terminal count; level, high exactly when CNT = 0.

Function
REQ-019 FSM states SHALL be IDLE, RD, WR, NEXT and DONE; all outputs SHALL be Moore, decoded from state and registers.
REQ-020 IDLE: cfg_we SHALL load the selected register on the rising edge. start with CNT != 0 SHALL go to RD. start with CNT = 0 SHALL go to DONE with no bus access.
REQ-021 Outside IDLE, cfg_we and start SHALL be ignored.
REQ-022 RD: bus_req = 1, bus_we = 0, bus_addr = SRC. bus_ack = 1 SHALL latch bus_rdata into an 8-bit HOLD register and go to WR; otherwise the FSM stays in RD.
REQ-023 WR: bus_req = 1, bus_we = 1, bus_addr = DST, bus_wdata = HOLD. bus_ack = 1 SHALL go to NEXT; otherwise the FSM stays in WR.
REQ-024 NEXT: SRC and DST SHALL each increment by 1, wrapping modulo 2^ADDR_W; CNT SHALL decrement by 1. The FSM goes to DONE if the old CNT = 1, else to RD.
REQ-025 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-026 Outside RD and WR, bus_req SHALL be 0, bus_we 0, bus_addr 0 and bus_wdata 0.
REQ-027 Beat timing: with bus_ack held high, one byte takes 3 cycles (RD, WR, NEXT). An N-byte transfer SHALL assert done 3N+1 cycles after the cycle in which start is sampled.
REQ-028 abort in any non-IDLE state SHALL go to IDLE on the next edge with no done pulse.
REQ-029 On abort, SRC, DST and CNT SHALL keep their current values, so a later start resumes at the remaining count.
REQ-030 abort together with bus_ack in the same cycle: abort wins; HOLD, SRC, DST and CNT SHALL NOT update from that beat.
REQ-031 abort in IDLE SHALL have no effect. start together with abort in IDLE: start wins.
REQ-032 CNT SHALL never underflow; NEXT is reachable only when CNT >= 1.

Reset
REQ-033 rst = 1 at a rising edge SHALL force IDLE and clear SRC, DST, CNT and HOLD to 0, in any state, including mid-beat.
REQ-034 After that edge: bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, busy = 0, done = 0, tc = 1.
REQ-035 rst SHALL take priority over start, abort, cfg_we and bus_ack.

Verification
REQ-036 Basic copy: SRC = 0x0010, DST = 0x0100, CNT = 3, memory bytes 0xA1/0xB2/0xC3, bus_ack tied high, start -> writes to 0x0100..0x0102 with 0xA1/0xB2/0xC3, done pulse 10 cycles after start, then tc = 1, SRC = 0x0013, DST = 0x0103.
REQ-037 Wait states: CNT = 1, bus_ack delayed 4 cycles per access -> bus_req and bus_addr held stable throughout, exactly one read and one write, single done pulse.
REQ-038 Wrap: SRC = 0xFFFF, DST = 0xFFFE, CNT = 2 -> reads at 0xFFFF then 0x0000, writes at 0xFFFE then 0xFFFF, final SRC = 0x0001, DST = 0x0000.
REQ-039 Zero count: CNT = 0, start -> no bus_req at any cycle, done high exactly in the cycle after start.
REQ-040 Abort then resume: CNT = 4, abort asserted in the second WR together with bus_ack -> IDLE, no done, CNT = 3; start again -> 3 more beats, then done.
REQ-041 Mid-beat reset: rst in RD while bus_ack = 1 -> next cycle all outputs at reset values, HOLD = 0, tc = 1; a start in the following cycle is ignored because CNT = 0 (done only, no bus access).

Source files
------------

// File: rtl/dmac_xfer_engine.sv
// Single-channel byte-copy DMA engine: reads a byte from SRC, writes it to DST,
// advances both pointers and repeats until CNT reaches zero.
module dmac_xfer_engine #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              start,
  input  logic              abort,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              done,
  output logic              tc
);

  typedef enum logic [2:0] {IDLE, RD, WR, NEXT, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          hold_q, hold_d;

  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [7:0]          bus_wdata_q, bus_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tc_q, tc_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          unique case (cfg_sel)
            2'd0:    src_d = cfg_data;
            2'd1:    dst_d = cfg_data;
            2'd2:    cnt_d = cfg_data[CNT_W-1:0];
            default: ;
          endcase
        end
        // Start decides on the count held before any same-cycle config write.
        if (start) state_d = (cnt_q == '0) ? DONE : RD;
      end
      RD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bus_ack) begin
          hold_d  = bus_rdata;
          state_d = WR;
        end
      end
      WR: begin
        if (abort)        state_d = IDLE;
        else if (bus_ack) state_d = NEXT;
      end
      NEXT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          state_d = (cnt_q <= CNT_W'(1)) ? DONE : RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values, so they track state_q exactly.
  always_comb begin
    bus_req_d   = (state_d == RD) || (state_d == WR);
    bus_we_d    = (state_d == WR);
    bus_addr_d  = '0;
    bus_wdata_d = '0;
    if (state_d == RD) bus_addr_d = src_d;
    if (state_d == WR) begin
      bus_addr_d  = dst_d;
      bus_wdata_d = hold_d;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    tc_d   = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tc_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tc_q        <= tc_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tc        = tc_q;

endmodule

// File: tb/tb_dmac_xfer_engine.sv
// Directed bench for dmac_xfer_engine: a memory model answers bus accesses and
// a scoreboard of expected reads/writes is checked as each access completes.
module tb_dmac_xfer_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        busy, done, tc;

  always #5 clk = ~clk;

  dmac_xfer_engine #(.ADDR_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .start(start), .abort(abort), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .busy(busy), .done(done), .tc(tc)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t        sb[$];
  logic [7:0]  mem [0:65535];
  int          n_cmp = 0, n_err = 0;
  int          cyc_n = 0, done_cnt = 0, last_done = -1, req_cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, wait_cnt = 0, ack_delay = 0;
  logic        pend = 1'b0, pend_we = 1'b0;
  logic [15:0] pend_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: answer the bus, score completed accesses, then advance past the edge.
  task automatic cyc();
    txn_t t;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    if (done === 1'b1) begin
      done_cnt++;
      last_done = cyc_n;
    end
    if (bus_req === 1'b1 && wait_cnt >= ack_delay) begin
      bus_ack = 1'b1;
      if (bus_we === 1'b0) bus_rdata = mem[bus_addr];
    end
    if (rst) begin
      wait_cnt = 0;
      pend     = 1'b0;
    end else if (bus_req === 1'b1) begin
      req_cyc++;
      if (pend) check("addr_stable", {15'd0, bus_we, bus_addr}, {15'd0, pend_we, pend_addr});
      if (bus_ack) begin
        wait_cnt = 0;
        pend     = 1'b0;
        if (!abort) begin
          n_cmp++;
          assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL sb_underflow: observed access at %0h, expected none", bus_addr);
          end
          if (sb.size() > 0) begin
            t = sb.pop_front();
            check("bus_we", {31'd0, bus_we}, {31'd0, t.we});
            check("bus_addr", {16'd0, bus_addr}, {16'd0, t.addr});
            if (t.we) begin
              check("bus_wdata", {24'd0, bus_wdata}, {24'd0, t.data});
              wr_cnt++;
            end else begin
              rd_cnt++;
            end
          end
        end
      end else begin
        wait_cnt++;
        pend      = 1'b1;
        pend_we   = bus_we;
        pend_addr = bus_addr;
      end
    end else begin
      wait_cnt = 0;
      pend     = 1'b0;
      check("bus_idle", {7'd0, bus_we, bus_addr, bus_wdata}, 32'd0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(output int t0);
    start = 1'b1;
    t0 = cyc_n;
    cyc();
    start = 1'b0;
  endtask

  task automatic expect_xfer(input logic [15:0] src, input logic [15:0] dst, input int n);
    logic [15:0] s, d;
    for (int i = 0; i < n; i++) begin
      s = src + 16'(i);
      d = dst + 16'(i);
      sb.push_back('{we: 1'b0, addr: s, data: 8'h00});
      sb.push_back('{we: 1'b1, addr: d, data: mem[s]});
    end
  endtask

  task automatic wait_done(input string tag, input int budget, input int exp_cyc);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_done_seen"}, done_cnt - d0, 1);
    check({tag, "_done_cycle"}, last_done, exp_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus"}, {6'd0, bus_req, bus_we, bus_addr, bus_wdata}, 32'd0);
    check({tag, "_flags"}, {29'd0, busy, done, tc}, 32'h1);
  endtask

  initial begin
    int t0, d0, r0, rd0, wr0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[16'h0010] = 8'hA1;
    mem[16'h0011] = 8'hB2;
    mem[16'h0012] = 8'hC3;

    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check_reset_outputs("reset");
    check("reset_cnt", {24'd0, dut.cnt_q}, 32'd0);

    // Configuration, reserved select, abort in IDLE
    cfg(2'd0, 16'h0010);
    cfg(2'd1, 16'h0100);
    cfg(2'd3, 16'hBEEF);
    check("cfg_src", {16'd0, dut.src_q}, 32'h0010);
    check("cfg_dst", {16'd0, dut.dst_q}, 32'h0100);
    check("cfg_rsvd_cnt", {24'd0, dut.cnt_q}, 32'd0);
    cfg(2'd2, 16'h1203);
    check("cfg_cnt_low", {24'd0, dut.cnt_q}, 32'd3);
    check("tc_nonzero", {31'd0, tc}, 32'd0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_cnt", {24'd0, dut.cnt_q}, 32'd3);

    // Basic 3-byte copy with ack tied high
    expect_xfer(16'h0010, 16'h0100, 3);
    do_start(t0);
    wait_done("basic", 40, t0 + 10);
    d0 = done_cnt;
    cyc(); cyc();
    check("basic_done_once", done_cnt - d0, 0);
    check("basic_tc", {31'd0, tc}, 32'd1);
    check("basic_src", {16'd0, dut.src_q}, 32'h0013);
    check("basic_dst", {16'd0, dut.dst_q}, 32'h0103);
    check("basic_sb_empty", sb.size(), 0);

    // Wait states: 4 idle cycles before each ack; config writes while busy ignored
    cfg(2'd2, 16'h0001);
    ack_delay = 4;
    rd0 = rd_cnt; wr0 = wr_cnt;
    expect_xfer(16'h0013, 16'h0103, 1);
    do_start(t0);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 16'h0055;
    repeat (8) cyc();
    cfg_we = 1'b0;
    wait_done("wait", 60, t0 + 12);
    d0 = done_cnt;
    cyc(); cyc();
    check("wait_done_once", done_cnt - d0, 0);
    check("wait_reads", rd_cnt - rd0, 1);
    check("wait_writes", wr_cnt - wr0, 1);
    check("wait_busy_cfg_ignored", {24'd0, dut.cnt_q}, 32'd0);
    check("wait_tc", {31'd0, tc}, 32'd1);
    ack_delay = 0;

    // Address wrap
    cfg(2'd0, 16'hFFFF);
    cfg(2'd1, 16'hFFFE);
    cfg(2'd2, 16'h0002);
    expect_xfer(16'hFFFF, 16'hFFFE, 2);
    do_start(t0);
    wait_done("wrap", 40, t0 + 7);
    check("wrap_src", {16'd0, dut.src_q}, 32'h0001);
    check("wrap_dst", {16'd0, dut.dst_q}, 32'h0000);
    check("wrap_sb_empty", sb.size(), 0);

    // Zero count: done next cycle, no bus access
    r0 = req_cyc;
    do_start(t0);
    wait_done("zero", 5, t0 + 1);
    check("zero_no_req", req_cyc - r0, 0);

    // Abort with ack in the second WR, then resume
    cfg(2'd0, 16'h0040);
    cfg(2'd1, 16'h0200);
    cfg(2'd2, 16'h0004);
    sb.push_back('{we: 1'b0, addr: 16'h0040, data: 8'h00});
    sb.push_back('{we: 1'b1, addr: 16'h0200, data: mem[16'h0040]});
    sb.push_back('{we: 1'b0, addr: 16'h0041, data: 8'h00});
    do_start(t0);
    repeat (4) cyc();
    check("abort_in_wr", {15'd0, bus_we, bus_addr}, {15'd0, 1'b1, 16'h0201});
    d0 = done_cnt;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cnt", {24'd0, dut.cnt_q}, 32'd3);
    check("abort_src", {16'd0, dut.src_q}, 32'h0041);
    check("abort_dst", {16'd0, dut.dst_q}, 32'h0201);
    cyc(); cyc();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_sb_empty", sb.size(), 0);
    expect_xfer(16'h0041, 16'h0201, 3);
    do_start(t0);
    wait_done("resume", 40, t0 + 10);
    check("resume_tc", {31'd0, tc}, 32'd1);
    check("resume_sb_empty", sb.size(), 0);

    // Reset in RD while bus_ack is high
    cfg(2'd0, 16'h0010);
    cfg(2'd1, 16'h0300);
    cfg(2'd2, 16'h0002);
    do_start(t0);
    check("rst_in_rd", {15'd0, bus_req, bus_addr}, {15'd0, 1'b1, 16'h0010});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outputs("midrst");
    check("midrst_hold", {24'd0, dut.hold_q}, 32'd0);
    check("midrst_src", {16'd0, dut.src_q}, 32'd0);
    r0 = req_cyc;
    do_start(t0);
    wait_done("midrst_start", 5, t0 + 1);
    check("midrst_no_req", req_cyc - r0, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
